// File: rtl/battle_front_scan.sv
// Scans N friendly and N enemy slots one index per cycle to find the leading
// unit on each side, then offsets both fronts with saturation and flags contact.
`timescale 1ns/1ps
module battle_front_scan #(
   parameter int N          = 16,
   parameter int LW         = 9,
   parameter int FRIEND_OFS = 6,
   parameter int ENEMY_OFS  = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   ack,
   input  logic [N*LW-1:0]        unit_loc,
   input  logic [2*N-1:0]         unit_type,
   input  logic [N*LW-1:0]        enemy_loc,
   input  logic [2*N-1:0]         enemy_type,
   input  logic [2:0]             type_mask,
   output logic [LW-1:0]          friendly_front,
   output logic [LW-1:0]          enemy_front,
   output logic [$clog2(N+1)-1:0] friendly_count,
   output logic [$clog2(N+1)-1:0] enemy_count,
   output logic [$clog2(N)-1:0]   lead_unit_idx,
   output logic [$clog2(N)-1:0]   lead_enemy_idx,
   output logic                   contact,
   output logic                   busy,
   output logic                   done,
   output logic [1:0]             dbgState
);

   localparam int CW = $clog2(N+1);
   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N-1);
   localparam logic [LW:0]   FOFS     = (LW+1)'(FRIEND_OFS);
   localparam logic [LW:0]   EOFS     = (LW+1)'(ENEMY_OFS);
   localparam logic [LW:0]   MAXV     = {1'b0, {LW{1'b1}}};

   typedef enum logic [1:0] {IDLE, SCAN, ADJUST, DONE} stateT;

   stateT           state, stateNext;
   logic [IW-1:0]   idx;
   logic [2:0]      maskLat;
   logic [LW-1:0]   uLoc, eLoc;
   logic [1:0]      uType, eType;
   logic            uPart, ePart;
   logic [3:0]      maskExt;
   logic [LW:0]     ffWide, ffSub, efSum;
   logic [LW-1:0]   friendlyAdj, enemyAdj;

   assign uLoc  = unit_loc[int'(idx)*LW +: LW];
   assign eLoc  = enemy_loc[int'(idx)*LW +: LW];
   assign uType = unit_type[int'(idx)*2 +: 2];
   assign eType = enemy_type[int'(idx)*2 +: 2];

   // Type 0 maps to a constant-zero mask bit, so empty slots never participate.
   assign maskExt = {maskLat, 1'b0};
   assign uPart   = maskExt[uType];
   assign ePart   = maskExt[eType];

   assign ffWide      = {1'b0, friendly_front};
   assign ffSub       = ffWide - FOFS;
   assign friendlyAdj = (ffWide >= FOFS) ? ffSub[LW-1:0] : '0;
   assign efSum       = {1'b0, enemy_front} + EOFS;
   assign enemyAdj    = (efSum > MAXV) ? MAXV[LW-1:0] : efSum[LW-1:0];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:   if (start) stateNext = SCAN;
         SCAN: begin
            busy = 1'b1;
            if (idx == LAST_IDX) stateNext = ADJUST;
         end
         ADJUST: begin
            busy      = 1'b1;
            stateNext = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (ack) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign dbgState = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx            <= '0;
         maskLat        <= 3'b111;
         friendly_front <= '1;
         enemy_front    <= '0;
         friendly_count <= '0;
         enemy_count    <= '0;
         lead_unit_idx  <= '0;
         lead_enemy_idx <= '0;
         contact        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               idx            <= '0;
               maskLat        <= type_mask;
               friendly_front <= '1;
               enemy_front    <= '0;
               friendly_count <= '0;
               enemy_count    <= '0;
               lead_unit_idx  <= '0;
               lead_enemy_idx <= '0;
               contact        <= 1'b0;
            end
            SCAN: begin
               idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
               // Strict compares keep the lowest index on ties.
               if (uPart) begin
                  friendly_count <= friendly_count + CW'(1);
                  if (uLoc < friendly_front) begin
                     friendly_front <= uLoc;
                     lead_unit_idx  <= idx;
                  end
               end
               if (ePart) begin
                  enemy_count <= enemy_count + CW'(1);
                  if (eLoc > enemy_front) begin
                     enemy_front    <= eLoc;
                     lead_enemy_idx <= idx;
                  end
               end
            end
            ADJUST: begin
               friendly_front <= friendlyAdj;
               enemy_front    <= enemyAdj;
               contact        <= (enemyAdj >= friendlyAdj);
            end
            default: ;
         endcase
      end
   end

endmodule
